apb_intc_lite: RTL and testbench

- APB slave for peripheral slot 4 of the APB bridge. That slot's select is already decoded and its read-data input is currently tied to zero.
- Consumes the 40-bit peripheral interrupt vector (UART, timer, GPIO, stimer sources) and provides per-source enable, level/edge mode, pending status and a claim register.
- Drives one registered interrupt request toward the core/PMU wake path.
- Same clock as all APB peripherals (per_clk domain), so no synchronizers are needed.

---
 rtl/apb_intc_pkg.sv | 29 ++
 rtl/intc_prio_enc.sv | 26 ++
 rtl/apb_intc_lite.sv | 185 ++++++++++++++++++
 tb/tb_apb_intc_lite.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_intc_pkg.sv
// Shared definitions for the APB interrupt controller (slot 4).
// Register offsets, default sizing and the claim-ID type.
package apb_intc_pkg;

    localparam int NUM_SRC_DEF = 40;
    localparam int ID_W_DEF    = 6;
    localparam int ADDR_W_DEF  = 12;

    typedef logic [ID_W_DEF-1:0] claim_id_t;

    localparam logic [11:0] OFF_PEND_LO = 12'h000;
    localparam logic [11:0] OFF_PEND_HI = 12'h004;
    localparam logic [11:0] OFF_EN_LO   = 12'h008;
    localparam logic [11:0] OFF_EN_HI   = 12'h00C;
    localparam logic [11:0] OFF_EDGE_LO = 12'h010;
    localparam logic [11:0] OFF_EDGE_HI = 12'h014;
    localparam logic [11:0] OFF_CLAIM   = 12'h018;
    localparam logic [11:0] OFF_PCLR    = 12'h01C;
    localparam logic [11:0] OFF_PCLR_HI = 12'h020;

    // CLAIM register value: id+1 of the winning source, 0 when none.
    function automatic logic [31:0] claim_word(
        input logic        valid,
        input logic [31:0] id
    );
        return valid ? (id + 32'd1) : 32'd0;
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder for the interrupt controller.
// Purely combinational; shared by the CLAIM read path and claim-clear.
module intc_prio_enc
    import apb_intc_pkg::*;
#(
    parameter int N    = NUM_SRC_DEF,
    parameter int ID_W = ID_W_DEF
) (
    input  logic [N-1:0]    req_i,
    output logic            valid_o,
    output logic [ID_W-1:0] id_o
);

    // Scan from the top down so the lowest set index is the last writer.
    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                id_o    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/apb_intc_lite.sv
// APB-attached interrupt controller: enable, level/edge mode, pending,
// fixed-priority claim and one registered request toward the core.
module apb_intc_lite
    import apb_intc_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    input  logic [NUM_SRC-1:0] int_src,
    output logic              intc_irq
);

    localparam int HI_W = NUM_SRC - 32;

    // State registers and their next-state values.
    logic [NUM_SRC-1:0] en_q;
    logic [NUM_SRC-1:0] en_d;
    logic [NUM_SRC-1:0] edge_q;
    logic [NUM_SRC-1:0] edge_d;
    logic [NUM_SRC-1:0] ep_q;
    logic [NUM_SRC-1:0] ep_d;
    logic [NUM_SRC-1:0] src_dly_q;
    logic               irq_q;
    logic               irq_d;

    // Bus decode.
    logic              acc;
    logic              rd_acc;
    logic              wr_acc;
    logic [ADDR_W-1:0] addr_w;
    logic              sel_pend_lo;
    logic              sel_pend_hi;
    logic              sel_en_lo;
    logic              sel_en_hi;
    logic              sel_edge_lo;
    logic              sel_edge_hi;
    logic              sel_claim;
    logic              sel_pclr;
    logic              sel_pclr_hi;
    logic              unused_addr;

    // Pending / claim datapath.
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] act;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pclr_mask;
    logic [NUM_SRC-1:0] claim_mask;
    logic [NUM_SRC-1:0] clr_mask;
    logic               enc_valid;
    logic [ID_W-1:0]    enc_id;
    logic [31:0]        claim_val;
    logic [63:0]        pend64;
    logic [63:0]        en64;
    logic [63:0]        edge64;
    logic [31:0]        rdata;

    assign acc    = psel & penable;
    assign rd_acc = acc & ~pwrite;
    assign wr_acc = acc & pwrite;

    // Byte lanes below the word boundary carry no meaning here.
    assign addr_w      = {paddr[ADDR_W-1:2], 2'b00};
    assign unused_addr = ^paddr[1:0];

    assign sel_pend_lo = (addr_w == ADDR_W'(OFF_PEND_LO));
    assign sel_pend_hi = (addr_w == ADDR_W'(OFF_PEND_HI));
    assign sel_en_lo   = (addr_w == ADDR_W'(OFF_EN_LO));
    assign sel_en_hi   = (addr_w == ADDR_W'(OFF_EN_HI));
    assign sel_edge_lo = (addr_w == ADDR_W'(OFF_EDGE_LO));
    assign sel_edge_hi = (addr_w == ADDR_W'(OFF_EDGE_HI));
    assign sel_claim   = (addr_w == ADDR_W'(OFF_CLAIM));
    assign sel_pclr    = (addr_w == ADDR_W'(OFF_PCLR));
    assign sel_pclr_hi = (addr_w == ADDR_W'(OFF_PCLR_HI));

    // Edge sources report their sticky flop; level sources the live line.
    assign pend = (ep_q & edge_q) | (int_src & ~edge_q);
    assign act  = pend & en_q;
    assign rise = int_src & ~src_dly_q & edge_q;

    intc_prio_enc #(
        .N    (NUM_SRC),
        .ID_W (ID_W)
    ) u_enc (
        .req_i   (act),
        .valid_o (enc_valid),
        .id_o    (enc_id)
    );

    assign claim_val = claim_word(enc_valid, 32'(enc_id));

    // One-hot clear of the source a CLAIM read hands out.
    always_comb begin
        claim_mask = '0;
        if (rd_acc && sel_claim && enc_valid) begin
            claim_mask[enc_id] = 1'b1;
        end
    end

    // Software W1C clears, split across the low and high words.
    always_comb begin
        pclr_mask = '0;
        if (wr_acc && sel_pclr) begin
            pclr_mask[31:0] = pwdata;
        end
        if (wr_acc && sel_pclr_hi) begin
            pclr_mask[NUM_SRC-1:32] = pwdata[HI_W-1:0];
        end
    end

    assign clr_mask = pclr_mask | claim_mask;

    // Edge flops: a new rise beats any clear; level mode forces zero.
    assign ep_d = (rise | (ep_q & ~clr_mask)) & edge_q;

    // Configuration register writes.
    always_comb begin
        en_d   = en_q;
        edge_d = edge_q;
        if (wr_acc) begin
            if (sel_en_lo) begin
                en_d[31:0] = pwdata;
            end
            if (sel_en_hi) begin
                en_d[NUM_SRC-1:32] = pwdata[HI_W-1:0];
            end
            if (sel_edge_lo) begin
                edge_d[31:0] = pwdata;
            end
            if (sel_edge_hi) begin
                edge_d[NUM_SRC-1:32] = pwdata[HI_W-1:0];
            end
        end
    end

    assign irq_d = |act;

    // Register update with synchronous reset.
    always_ff @(posedge pclk) begin
        if (prst) begin
            en_q      <= '0;
            edge_q    <= '0;
            ep_q      <= '0;
            src_dly_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            edge_q    <= edge_d;
            ep_q      <= ep_d;
            src_dly_q <= int_src;
            irq_q     <= irq_d;
        end
    end

    assign pend64 = 64'(pend);
    assign en64   = 64'(en_q);
    assign edge64 = 64'(edge_q);

    // Read mux; write-only and unmapped offsets return zero.
    always_comb begin
        rdata = 32'd0;
        unique case (1'b1)
            sel_pend_lo: rdata = pend64[31:0];
            sel_pend_hi: rdata = pend64[63:32];
            sel_en_lo:   rdata = en64[31:0];
            sel_en_hi:   rdata = en64[63:32];
            sel_edge_lo: rdata = edge64[31:0];
            sel_edge_hi: rdata = edge64[63:32];
            sel_claim:   rdata = claim_val;
            default:     rdata = 32'd0;
        endcase
    end

    assign prdata   = rd_acc ? rdata : 32'd0;
    assign intc_irq = irq_q;

endmodule

// File: tb/tb_apb_intc_lite.sv
// Self-checking bench for apb_intc_lite: directed scenarios followed
// by random bus traffic against a source-by-source reference model.
module tb_apb_intc_lite;

    localparam int N = 40;

    logic        pclk;
    logic        prst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic [N-1:0] int_src;
    logic        intc_irq;

    int n_chk;
    int n_err;

    // Reference model state, one bit per source.
    bit [N-1:0] en_m;
    bit [N-1:0] edg_m;
    bit [N-1:0] ep_m;
    bit [N-1:0] prev_m;
    bit         irq_m;

    apb_intc_lite dut (
        .pclk     (pclk),
        .prst     (prst),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .int_src  (int_src),
        .intc_irq (intc_irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit [N-1:0] m_pend();
        bit [N-1:0] p;
        for (int i = 0; i < N; i++) begin
            if (edg_m[i]) p[i] = ep_m[i];
            else          p[i] = int_src[i];
        end
        return p;
    endfunction

    function automatic int m_claim();
        bit [N-1:0] p;
        p = m_pend();
        for (int i = 0; i < N; i++) begin
            if (p[i] && en_m[i]) return i + 1;
        end
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        bit [N-1:0] p;
        logic [11:0] w;
        p = m_pend();
        w = {a[11:2], 2'b00};
        case (w)
            12'h000: return p[31:0];
            12'h004: return {24'd0, p[39:32]};
            12'h008: return en_m[31:0];
            12'h00C: return {24'd0, en_m[39:32]};
            12'h010: return edg_m[31:0];
            12'h014: return {24'd0, edg_m[39:32]};
            12'h018: return 32'(m_claim());
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic m_edge();
        bit [N-1:0] p;
        bit [N-1:0] clr;
        bit [N-1:0] nep;
        bit         acc;
        bit         any;
        int         cv;
        logic [11:0] w;
        if (prst) begin
            en_m = '0; edg_m = '0; ep_m = '0; prev_m = '0; irq_m = 0;
            return;
        end
        acc = psel && penable;
        w   = {paddr[11:2], 2'b00};
        p   = m_pend();
        cv  = m_claim();
        any = |(p & en_m);
        clr = '0;
        if (acc && pwrite && w == 12'h01C) clr[31:0] = pwdata;
        if (acc && pwrite && w == 12'h020) clr[39:32] = pwdata[7:0];
        if (acc && !pwrite && w == 12'h018 && cv != 0) clr[cv-1] = 1;
        for (int i = 0; i < N; i++) begin
            nep[i] = edg_m[i] &&
                     ((int_src[i] && !prev_m[i]) || (ep_m[i] && !clr[i]));
        end
        if (acc && pwrite) begin
            case (w)
                12'h008: en_m[31:0]   = pwdata;
                12'h00C: en_m[39:32]  = pwdata[7:0];
                12'h010: edg_m[31:0]  = pwdata;
                12'h014: edg_m[39:32] = pwdata[7:0];
                default: ;
            endcase
        end
        prev_m = int_src;
        ep_m   = nep;
        irq_m  = any;
    endtask

    task automatic tick();
        m_edge();
        @(posedge pclk);
        #1;
        check("irq", {31'd0, intc_irq}, {31'd0, irq_m});
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        tick();
        penable = 1;
        #1;
        check("wr_prdata", prdata, 32'd0);
        tick();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        tick();
        penable = 1;
        #1;
        d = prdata;
        check("rd_model", prdata, m_read(a));
        tick();
        psel = 0; penable = 0;
    endtask

    logic [31:0] d;
    logic [11:0] ra;

    initial begin
        n_chk = 0; n_err = 0;
        prst = 1; psel = 0; penable = 0; pwrite = 0;
        paddr = '0; pwdata = '0; int_src = '0;
        en_m = '0; edg_m = '0; ep_m = '0; prev_m = '0; irq_m = 0;
        tick();
        tick();
        prst = 0;

        // 1: reset state of every register
        for (int k = 0; k < 9; k++) begin
            apb_read(12'(k * 4), d);
            check("rst_reg", d, 32'd0);
        end
        apb_read(12'h03C, d);
        check("rst_unmapped", d, 32'd0);
        check("rst_irq", {31'd0, intc_irq}, 32'd0);

        // 2: level source 1
        apb_write(12'h008, 32'h2);
        int_src[1] = 1;
        tick();
        check("lvl_irq_hi", {31'd0, intc_irq}, 32'd1);
        apb_read(12'h018, d);
        check("lvl_claim", d, 32'd2);
        int_src[1] = 0;
        tick();
        check("lvl_irq_lo", {31'd0, intc_irq}, 32'd0);
        apb_read(12'h018, d);
        check("lvl_claim0", d, 32'd0);

        // 3: edge source 5, single-cycle pulse
        apb_write(12'h010, 32'h20);
        apb_write(12'h008, 32'h20);
        int_src[5] = 1;
        tick();
        check("edg_irq_n1", {31'd0, intc_irq}, 32'd0);
        int_src[5] = 0;
        tick();
        check("edg_irq_n2", {31'd0, intc_irq}, 32'd1);
        apb_read(12'h000, d);
        check("edg_pend", d, 32'h20);
        apb_read(12'h018, d);
        check("edg_claim", d, 32'd6);
        apb_read(12'h000, d);
        check("edg_pend_clr", d, 32'd0);
        check("edg_irq_lo", {31'd0, intc_irq}, 32'd0);

        // 4: priority between level src 3 and edge src 34
        apb_write(12'h010, 32'h0);
        apb_write(12'h014, 32'h4);
        apb_write(12'h008, 32'h8);
        apb_write(12'h00C, 32'h4);
        int_src[3] = 1;
        int_src[34] = 1;
        tick();
        int_src[34] = 0;
        tick();
        apb_read(12'h018, d);
        check("prio_claim4", d, 32'd4);
        int_src[3] = 0;
        tick();
        apb_read(12'h018, d);
        check("prio_claim35", d, 32'd35);
        apb_read(12'h018, d);
        check("prio_claim0", d, 32'd0);

        // 5: PCLR collides with a new rise on edge src 5
        apb_write(12'h010, 32'h20);
        apb_write(12'h008, 32'h20);
        int_src[5] = 1;
        tick();
        int_src[5] = 0;
        tick();
        psel = 1; penable = 0; pwrite = 1; paddr = 12'h01C; pwdata = 32'h20;
        tick();
        penable = 1;
        int_src[5] = 1;
        tick();
        psel = 0; penable = 0; pwrite = 0;
        int_src[5] = 0;
        apb_read(12'h000, d);
        check("coll_pend", d, 32'h20);
        apb_write(12'h01C, 32'h20);
        apb_read(12'h000, d);
        check("pclr_pend", d, 32'd0);
        int_src[5] = 1;
        tick();
        int_src[5] = 0;
        tick();

        // 6: reset during a CLAIM access phase
        psel = 1; penable = 0; pwrite = 0; paddr = 12'h018;
        tick();
        penable = 1;
        prst = 1;
        tick();
        prst = 0; psel = 0; penable = 0;
        tick();
        apb_read(12'h000, d);
        check("mrst_pend", d, 32'd0);
        apb_read(12'h008, d);
        check("mrst_en_lo", d, 32'd0);
        apb_read(12'h00C, d);
        check("mrst_en_hi", d, 32'd0);
        check("mrst_irq", {31'd0, intc_irq}, 32'd0);

        // Random traffic against the model
        for (int it = 0; it < 3000; it++) begin
            int op;
            int sel;
            if ($urandom_range(2) == 0) begin
                int b;
                b = $urandom_range(N - 1);
                int_src[b] = ~int_src[b];
            end
            sel = $urandom_range(11);
            if (sel < 9)        ra = 12'(sel * 4);
            else if (sel == 9)  ra = 12'h03C;
            else if (sel == 10) ra = 12'h024;
            else                ra = 12'($urandom);
            ra[1:0] = 2'($urandom_range(3));
            op = $urandom_range(9);
            if (op <= 3) begin
                tick();
                check("idle_prdata", prdata, 32'd0);
            end else if (op <= 6) begin
                apb_write(ra, $urandom);
            end else if (op <= 8) begin
                apb_read(ra, d);
            end else if ($urandom_range(40) == 0) begin
                prst = 1;
                tick();
                prst = 0;
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
